// File: rtl/led_disp_rx.sv
//------------------------------------------------------------------------------
// Module   : led_disp_rx
// Function : Six-digit multiplexed seven-segment receiver; settles, decodes and
//            reassembles scanned digits into BCD and binary hour/min/sec.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_disp_rx #(
   parameter int STABLE_CYC     = 4,
   parameter int ENB_ACTIVE_LOW = 0,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  i_seg_enb,
   input  logic [6:0]  i_seg,
   input  logic        i_seg_dp,
   output logic [23:0] o_six_digit,
   output logic [5:0]  o_blank,
   output logic [5:0]  o_seg_err,
   output logic [5:0]  o_dp,
   output logic [6:0]  o_hour,
   output logic [6:0]  o_min,
   output logic [6:0]  o_sec,
   output logic        o_frame_valid,
   output logic        o_enb_err
);

   localparam logic [7:0] c_cnt_sat  = 8'(STABLE_CYC);
   localparam logic [7:0] c_cnt_fire = 8'(STABLE_CYC - 2);
   localparam logic [5:0] c_mask_all = 6'h3F;

   // Returns {err, blank, bcd[3:0]}
   function automatic logic [5:0] decode_seg(input logic [6:0] pat);
      logic [5:0] res;
      case (pat)
         7'h3F:   res = 6'b00_0000;
         7'h06:   res = 6'b00_0001;
         7'h5B:   res = 6'b00_0010;
         7'h4F:   res = 6'b00_0011;
         7'h66:   res = 6'b00_0100;
         7'h6D:   res = 6'b00_0101;
         7'h7D:   res = 6'b00_0110;
         7'h07:   res = 6'b00_0111;
         7'h7F:   res = 6'b00_1000;
         7'h6F:   res = 6'b00_1001;
         7'h00:   res = 6'b01_0000;
         default: res = 6'b10_1111;
      endcase
      return res;
   endfunction

   function automatic logic [6:0] to_bin(input logic [3:0] tens, input logic [3:0] ones);
      return {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};
   endfunction

   logic [5:0]  w_enb_norm;
   logic [6:0]  w_seg_norm;
   logic        w_dp_norm;
   logic [5:0]  r_enb;
   logic [6:0]  r_seg;
   logic        r_dp;
   logic [7:0]  r_cnt;
   logic        w_diff;
   logic        w_fire;
   logic        w_enb_any;
   logic        w_enb_multi;
   logic        w_capture;
   logic        w_commit;
   logic [5:0]  w_dec;

   logic [5:0]  r_mask;
   logic [23:0] r_sh_bcd;
   logic [5:0]  r_sh_blank;
   logic [5:0]  r_sh_err;
   logic [5:0]  r_sh_dp;
   logic [23:0] w_val;

   logic [23:0] r_six_digit;
   logic [5:0]  r_blank;
   logic [5:0]  r_seg_err;
   logic [5:0]  r_dp_out;
   logic [6:0]  r_hour;
   logic [6:0]  r_min;
   logic [6:0]  r_sec;
   logic        r_frame_valid;
   logic        r_enb_err;

   assign w_enb_norm = (ENB_ACTIVE_LOW != 0) ? ~i_seg_enb : i_seg_enb;
   assign w_seg_norm = (SEG_ACTIVE_LOW != 0) ? ~i_seg    : i_seg;
   assign w_dp_norm  = (SEG_ACTIVE_LOW != 0) ? ~i_seg_dp : i_seg_dp;

   // The counter restarts on the same edge a new value enters the input
   // register, so it reaches STABLE_CYC-1 exactly STABLE_CYC edges after a change.
   assign w_diff = {w_enb_norm, w_seg_norm, w_dp_norm} != {r_enb, r_seg, r_dp};
   assign w_fire = !w_diff && (r_cnt == c_cnt_fire);

   assign w_enb_any   = |r_enb;
   assign w_enb_multi = (r_enb & (r_enb - 6'd1)) != 6'd0;
   assign w_capture   = w_fire && w_enb_any && !w_enb_multi;
   assign w_commit    = (r_mask == c_mask_all);
   assign w_dec       = decode_seg(r_seg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enb <= 6'd0;
         r_seg <= 7'd0;
         r_dp  <= 1'b0;
         r_cnt <= 8'd0;
      end else begin
         r_enb <= w_enb_norm;
         r_seg <= w_seg_norm;
         r_dp  <= w_dp_norm;
         if (w_diff)
            r_cnt <= 8'd0;
         else if (r_cnt != c_cnt_sat)
            r_cnt <= r_cnt + 8'd1;
      end
   end

   // Blank or erroneous digits contribute zero to the binary result
   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_digit_val
         assign w_val[gi*4 +: 4] = (r_sh_blank[gi] || r_sh_err[gi]) ? 4'd0 : r_sh_bcd[gi*4 +: 4];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask        <= 6'd0;
         r_sh_bcd      <= 24'd0;
         r_sh_blank    <= 6'd0;
         r_sh_err      <= 6'd0;
         r_sh_dp       <= 6'd0;
         r_six_digit   <= 24'd0;
         r_blank       <= 6'd0;
         r_seg_err     <= 6'd0;
         r_dp_out      <= 6'd0;
         r_hour        <= 7'd0;
         r_min         <= 7'd0;
         r_sec         <= 7'd0;
         r_frame_valid <= 1'b0;
         r_enb_err     <= 1'b0;
      end else begin
         r_frame_valid <= w_commit;
         r_enb_err     <= w_fire && w_enb_multi;

         if (w_commit) begin
            r_six_digit <= r_sh_bcd;
            r_blank     <= r_sh_blank;
            r_seg_err   <= r_sh_err;
            r_dp_out    <= r_sh_dp;
            r_hour      <= to_bin(w_val[23:20], w_val[19:16]);
            r_min       <= to_bin(w_val[15:12], w_val[11:8]);
            r_sec       <= to_bin(w_val[7:4],   w_val[3:0]);
         end

         // A capture coinciding with a commit starts the next frame's mask
         r_mask <= (w_commit ? 6'd0 : r_mask) | (w_capture ? r_enb : 6'd0);

         if (w_capture) begin
            for (int i = 0; i < 6; i++) begin
               if (r_enb[i]) begin
                  r_sh_bcd[i*4 +: 4] <= w_dec[3:0];
                  r_sh_blank[i]      <= w_dec[4];
                  r_sh_err[i]        <= w_dec[5];
                  r_sh_dp[i]         <= r_dp;
               end
            end
         end
      end
   end

   assign o_six_digit   = r_six_digit;
   assign o_blank       = r_blank;
   assign o_seg_err     = r_seg_err;
   assign o_dp          = r_dp_out;
   assign o_hour        = r_hour;
   assign o_min         = r_min;
   assign o_sec         = r_sec;
   assign o_frame_valid = r_frame_valid;
   assign o_enb_err     = r_enb_err;

endmodule

`default_nettype wire

// File: tb/tb_led_disp_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_led_disp_rx
// Function : Directed bench for led_disp_rx with a per-cycle behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_disp_rx;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  seg_enb = 6'd0;
   logic [6:0]  seg = 7'd0;
   logic        seg_dp = 1'b0;
   logic [23:0] o_six_digit;
   logic [5:0]  o_blank, o_seg_err, o_dp;
   logic [6:0]  o_hour, o_min, o_sec;
   logic        o_frame_valid, o_enb_err;

   always #5 clk = ~clk;

   led_disp_rx #(.STABLE_CYC(S), .ENB_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_seg_enb(seg_enb), .i_seg(seg), .i_seg_dp(seg_dp),
      .o_six_digit(o_six_digit), .o_blank(o_blank), .o_seg_err(o_seg_err), .o_dp(o_dp),
      .o_hour(o_hour), .o_min(o_min), .o_sec(o_sec),
      .o_frame_valid(o_frame_valid), .o_enb_err(o_enb_err)
   );

   logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   int n_vec = 0;
   int n_err = 0;
   int fv_seen = 0;
   int ee_seen = 0;

   // behavioural model state
   logic [13:0] m_prev;
   int          m_run;
   logic [5:0]  m_mask;
   int          m_bcd [6];
   bit          m_blank [6], m_err [6], m_dp [6];
   logic [23:0] e_digit;
   logic [5:0]  e_blank, e_err, e_dp;
   logic [6:0]  e_hour, e_min, e_sec;
   logic        e_fv, e_ee;

   logic [6:0]  sp [6];
   logic [5:0]  sdp = 6'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_prev = 14'd0; m_run = 1; m_mask = 6'd0;
      for (int i = 0; i < 6; i++) begin
         m_bcd[i] = 0; m_blank[i] = 0; m_err[i] = 0; m_dp[i] = 0;
      end
      e_digit = 24'd0; e_blank = 6'd0; e_err = 6'd0; e_dp = 6'd0;
      e_hour = 7'd0; e_min = 7'd0; e_sec = 7'd0; e_fv = 1'b0; e_ee = 1'b0;
   endtask

   function automatic int dval(input int i);
      return (m_blank[i] || m_err[i]) ? 0 : m_bcd[i];
   endfunction

   task automatic model_step(input logic [5:0] enb, input logic [6:0] s, input logic d);
      logic [13:0] x;
      int ones, b;
      x = {enb, s, d};
      if (x == m_prev) begin
         if (m_run < 1000) m_run++;
      end else m_run = 1;
      m_prev = x;
      e_fv = 1'b0; e_ee = 1'b0;
      if (m_mask == 6'h3F) begin
         for (int i = 0; i < 6; i++) begin
            e_digit[i*4 +: 4] = 4'(m_bcd[i]);
            e_blank[i] = m_blank[i]; e_err[i] = m_err[i]; e_dp[i] = m_dp[i];
         end
         e_hour = 7'(dval(5) * 10 + dval(4));
         e_min  = 7'(dval(3) * 10 + dval(2));
         e_sec  = 7'(dval(1) * 10 + dval(0));
         e_fv = 1'b1;
         m_mask = 6'd0;
      end
      if (m_run == S) begin
         ones = $countones(enb);
         if (ones >= 2) e_ee = 1'b1;
         else if (ones == 1) begin
            for (int i = 0; i < 6; i++) begin
               if (enb[i]) begin
                  b = 15; m_blank[i] = 0; m_err[i] = 0;
                  if (s == 7'h00) begin b = 0; m_blank[i] = 1; end
                  else begin
                     for (int v = 0; v < 10; v++) if (pat[v] == s) b = v;
                     if (b == 15) m_err[i] = 1;
                  end
                  m_bcd[i] = b; m_dp[i] = d; m_mask[i] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("six_digit", 32'(o_six_digit), 32'(e_digit));
      chk("blank", 32'(o_blank), 32'(e_blank));
      chk("seg_err", 32'(o_seg_err), 32'(e_err));
      chk("dp", 32'(o_dp), 32'(e_dp));
      chk("hour", 32'(o_hour), 32'(e_hour));
      chk("min", 32'(o_min), 32'(e_min));
      chk("sec", 32'(o_sec), 32'(e_sec));
      chk("frame_valid", 32'(o_frame_valid), 32'(e_fv));
      chk("enb_err", 32'(o_enb_err), 32'(e_ee));
   endtask

   task automatic tick(input logic [5:0] enb, input logic [6:0] s, input logic d);
      seg_enb = enb; seg = s; seg_dp = d;
      @(posedge clk);
      model_step(enb, s, d);
      #1;
      compare_all();
      if (o_frame_valid) fv_seen++;
      if (o_enb_err) ee_seen++;
   endtask

   task automatic do_reset();
      seg_enb = 6'd0; seg = 7'd0; seg_dp = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;
   endtask

   task automatic set_digits(input logic [23:0] v);
      for (int i = 0; i < 6; i++) sp[i] = pat[v[i*4 +: 4]];
   endtask

   task automatic scan(input int dwell, input int first, input int last);
      for (int i = first; i >= last; i--)
         repeat (dwell) tick(6'd1 << i, sp[i], sdp[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(6'd0, 7'd0, 1'b0);
   endtask

   int fv0, ee0;

   initial begin
      do_reset();
      chk("reset_digits", 32'(o_six_digit), 32'h0);
      chk("reset_fv", 32'(o_frame_valid), 32'h0);

      // basic frame
      set_digits(24'h123456); sdp = 6'b010000;
      fv0 = fv_seen;
      scan(20, 5, 0); idle(3);
      chk("t1_frames", 32'(fv_seen - fv0), 32'd1);
      chk("t1_digits", 32'(o_six_digit), 32'h123456);
      chk("t1_hour", 32'(o_hour), 32'd12);
      chk("t1_min", 32'(o_min), 32'd34);
      chk("t1_sec", 32'(o_sec), 32'd56);
      chk("t1_blank", 32'(o_blank), 32'h0);
      chk("t1_err", 32'(o_seg_err), 32'h0);
      chk("t1_dp", 32'(o_dp), 32'b010000);

      // blinked-off minutes
      sdp = 6'd0; sp[3] = 7'h00; sp[2] = 7'h00;
      scan(20, 5, 0); idle(3);
      chk("t2_blank", 32'(o_blank), 32'b001100);
      chk("t2_min", 32'(o_min), 32'd0);
      chk("t2_hour", 32'(o_hour), 32'd12);
      chk("t2_digits", 32'(o_six_digit), 32'h120056);

      // illegal segment pattern on sec0
      set_digits(24'h123456); sp[0] = 7'h49;
      scan(20, 5, 0); idle(3);
      chk("t3_sec0", 32'(o_six_digit[3:0]), 32'hF);
      chk("t3_err", 32'(o_seg_err), 32'b000001);
      chk("t3_sec", 32'(o_sec), 32'd50);

      // two enables at once in the middle of a frame
      set_digits(24'h123456);
      scan(20, 5, 4);
      ee0 = ee_seen; fv0 = fv_seen;
      repeat (10) tick(6'b000011, 7'h06, 1'b0);
      chk("t4_enb_err", 32'(ee_seen - ee0), 32'd1);
      scan(20, 3, 0); idle(3);
      chk("t4_frames", 32'(fv_seen - fv0), 32'd1);
      chk("t4_hour", 32'(o_hour), 32'd12);
      chk("t4_sec", 32'(o_sec), 32'd56);

      // dwell too short, then just long enough
      set_digits(24'h235959);
      fv0 = fv_seen;
      repeat (2) scan(3, 5, 0);
      idle(4);
      chk("t5_short_frames", 32'(fv_seen - fv0), 32'd0);
      chk("t5_short_hour", 32'(o_hour), 32'd12);
      scan(5, 5, 0); idle(2);
      chk("t5_frames", 32'(fv_seen - fv0), 32'd1);
      chk("t5_hour", 32'(o_hour), 32'd23);
      chk("t5_min", 32'(o_min), 32'd59);
      chk("t5_sec", 32'(o_sec), 32'd59);

      // reset after four captured digits
      set_digits(24'h081530);
      scan(20, 5, 2);
      do_reset();
      chk("t6_rst_digits", 32'(o_six_digit), 32'h0);
      chk("t6_rst_hour", 32'(o_hour), 32'h0);
      fv0 = fv_seen;
      scan(20, 1, 0); idle(3);
      chk("t6_partial_frames", 32'(fv_seen - fv0), 32'd0);
      scan(20, 5, 0); idle(3);
      chk("t6_frames", 32'(fv_seen - fv0), 32'd1);
      chk("t6_digits", 32'(o_six_digit), 32'h081530);
      chk("t6_min", 32'(o_min), 32'd15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
